// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC register and req/ack instruction fetch stage feeding the main decoder (optional jr path: IFETCH_JR_EN)
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  OpCode,
    output logic        instr_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        instr_done,
    input  logic        Jump,
    input  logic        Branch,
    input  logic        BranchNotEqual,
    input  logic        Zero,
    output logic        fetch_fault
`ifdef IFETCH_JR_EN
    ,
    input  logic        JumpReg,
    input  logic [31:0] rs_data
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HOLD,
        S_FAULT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  wait_cnt;
    logic        time_up;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] pc_next;

    assign imem_addr = pc;
    assign OpCode    = instr[31:26];
    assign pc_plus4  = pc + 32'd4;

    // The TIMEOUT-th consecutive ack-less FETCH cycle is the one where the counter reads TIMEOUT-1.
    assign time_up = (wait_cnt == 8'(TIMEOUT - 1));

    assign branch_taken  = Branch & (Zero ^ BranchNotEqual);
    assign branch_target = pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00};
    assign jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};

    // Next-PC selection in priority order; only consumed on the retire edge in HOLD.
    always_comb begin
        pc_next = pc_plus4;
        if (Jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
`ifdef IFETCH_JR_EN
        if (JumpReg) begin
            pc_next = rs_data & 32'hFFFF_FFFC;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded handshake/status outputs.
    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        fetch_fault = 1'b0;
        case (state)
            S_IDLE: begin
                state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    state_next = S_HOLD;
                end else if (time_up) begin
                    state_next = S_FAULT;
                end
            end
            S_HOLD: begin
                instr_valid = 1'b1;
                if (instr_done) begin
                    state_next = S_FETCH;
                end
            end
            S_FAULT: begin
                fetch_fault = 1'b1;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // PC, instruction register and ack-wait counter; the counter idles at zero outside FETCH.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= RESET_PC;
            instr    <= 32'd0;
            wait_cnt <= 8'd0;
        end else begin
            if (state != S_FETCH) begin
                wait_cnt <= 8'd0;
            end else if (!imem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == S_FETCH && imem_ack) begin
                instr <= imem_rdata;
            end
            if (state == S_HOLD && instr_done) begin
                pc <= pc_next;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - randomized self-checking bench for instr_fetch_unit
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TIMEOUT  = 16;
`ifdef IFETCH_JR_EN
    localparam bit JR_EN = 1'b1;
`else
    localparam bit JR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic [31:0] instr;
    logic [5:0]  OpCode;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        instr_done = 1'b0;
    logic        Jump = 1'b0;
    logic        Branch = 1'b0;
    logic        BranchNotEqual = 1'b0;
    logic        Zero = 1'b0;
    logic        fetch_fault;
`ifdef IFETCH_JR_EN
    logic        JumpReg = 1'b0;
    logic [31:0] rs_data = 32'd0;
`endif

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] mpc;
    logic [31:0] minstr;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .OpCode        (OpCode),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr_done    (instr_done),
        .Jump          (Jump),
        .Branch        (Branch),
        .BranchNotEqual(BranchNotEqual),
        .Zero          (Zero),
        .fetch_fault   (fetch_fault)
`ifdef IFETCH_JR_EN
        ,
        .JumpReg       (JumpReg),
        .rs_data       (rs_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Architectural next-PC rule, computed arithmetically.
    function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                               input bit j, input bit b, input bit bne, input bit z,
                                               input bit jr, input logic [31:0] rs);
        int off;
        if (JR_EN && jr) return rs & ~32'd3;
        if (j) return ((p + 32'd4) & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        if (b && (z != bne)) begin
            off = int'(ins & 32'h0000_FFFF);
            if (off >= 32768) off -= 65536;
            return p + 32'd4 + 32'(off * 4);
        end
        return p + 32'd4;
    endfunction

    task automatic do_reset();
        reset = 1'b1; imem_ack = 1'b0; instr_done = 1'b0;
        Jump = 1'b0; Branch = 1'b0; BranchNotEqual = 1'b0; Zero = 1'b0;
        step();
        step();
        mpc = RESET_PC;
        check("rst_pc", pc, RESET_PC);
        check("rst_instr", instr, 32'd0);
        check("rst_valid", instr_valid, 0);
        check("rst_req", imem_req, 0);
        check("rst_fault", fetch_fault, 0);
        reset = 1'b0;
        step();
    endtask

    // Called while the DUT is in FETCH; ack arrives on cycle wait_n (0-based).
    task automatic fetch_instr(input int wait_n, input logic [31:0] word, input bit noise);
        for (int i = 0; i <= wait_n; i++) begin
            check("f_req", imem_req, 1);
            check("f_addr", imem_addr, mpc);
            check("f_valid", instr_valid, 0);
            imem_ack   = (i == wait_n);
            imem_rdata = (i == wait_n) ? word : $urandom;
            instr_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            Jump       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            Branch     = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            Zero       = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            step();
        end
        imem_ack = 1'b0; instr_done = 1'b0;
        Jump = 1'b0; Branch = 1'b0; BranchNotEqual = 1'b0; Zero = 1'b0;
        minstr = word;
        check("h_valid", instr_valid, 1);
        check("h_req", imem_req, 0);
        check("h_instr", instr, word);
        check("h_opcode", OpCode, word >> 26);
        check("h_pc", pc, mpc);
        check("h_pc4", pc_plus4, mpc + 32'd4);
    endtask

    // Called while the DUT is in HOLD; retires after hold_n idle cycles.
    task automatic retire(input int hold_n, input bit j, input bit b, input bit bne, input bit z,
                          input bit jr, input logic [31:0] rs);
        for (int i = 0; i < hold_n; i++) begin
            Jump = 1'($urandom_range(0, 1));
            Branch = 1'($urandom_range(0, 1));
            imem_ack = 1'($urandom_range(0, 1));
            step();
            check("hold_instr", instr, minstr);
            check("hold_valid", instr_valid, 1);
        end
        imem_ack = 1'b0;
        Jump = j; Branch = b; BranchNotEqual = bne; Zero = z; instr_done = 1'b1;
`ifdef IFETCH_JR_EN
        JumpReg = jr; rs_data = rs;
`endif
        step();
        instr_done = 1'b0; Jump = 1'b0; Branch = 1'b0; BranchNotEqual = 1'b0; Zero = 1'b0;
`ifdef IFETCH_JR_EN
        JumpReg = 1'b0;
`endif
        mpc = model_next(mpc, minstr, j, b, bne, z, jr, rs);
        check("r_pc", pc, mpc);
        check("r_valid", instr_valid, 0);
        check("r_req", imem_req, 1);
    endtask

    initial begin
        int w;
        logic [31:0] word;
        bit j, b, bne, z;

        // Reset, zero-wait ack, sequential retire.
        do_reset();
        fetch_instr(0, 32'h2008_0005, 1'b0);
        check("opcode_08", OpCode, 32'h08);
        retire(0, 0, 0, 0, 0, 0, 32'd0);
        check("addr_4", imem_addr, 32'h4);

        // Branch cases at pc 0x10.
        fetch_instr(0, 32'h0800_0004, 1'b0);
        retire(0, 1, 0, 0, 0, 0, 32'd0);
        fetch_instr(1, 32'h1000_FFFF, 1'b0);
        retire(1, 0, 1, 0, 1, 0, 32'd0);
        check("beq_taken", pc, 32'h10);
        fetch_instr(0, 32'h1000_FFFF, 1'b0);
        retire(0, 0, 1, 1, 1, 0, 32'd0);
        check("bne_not_taken", pc, 32'h14);
        fetch_instr(0, 32'h0800_0004, 1'b0);
        retire(0, 1, 0, 0, 0, 0, 32'd0);
        fetch_instr(0, 32'h1000_FFFF, 1'b0);
        retire(0, 0, 1, 1, 0, 0, 32'd0);
        check("bne_taken", pc, 32'h10);

        // Walk up to 0x4000_0010 with maximal forward branches.
        for (int i = 0; i < 8192; i++) begin
            imem_ack = 1'b1; imem_rdata = 32'h1000_7FFF;
            step();
            imem_ack = 1'b0; instr_done = 1'b1; Branch = 1'b1; Zero = 1'b1;
            step();
            instr_done = 1'b0; Branch = 1'b0; Zero = 1'b0;
            mpc = model_next(mpc, 32'h1000_7FFF, 0, 1, 0, 1, 0, 32'd0);
        end
        check("walk_pc", pc, 32'h4000_0010);

        // Jump, then jump with branch also asserted.
        fetch_instr(0, 32'h0800_0100, 1'b0);
        retire(0, 1, 0, 0, 0, 0, 32'd0);
        check("jump", pc, 32'h4000_0400);
        fetch_instr(0, 32'h1000_FF03, 1'b0);
        retire(0, 0, 1, 0, 1, 0, 32'd0);
        check("back_to_10", pc, 32'h4000_0010);
        fetch_instr(0, 32'h0800_0100, 1'b0);
        retire(0, 1, 1, 0, 1, 0, 32'd0);
        check("jump_prio", pc, 32'h4000_0400);

        // Ack on the last permitted cycle is accepted.
        fetch_instr(TIMEOUT - 1, 32'hDEAD_BEEF, 1'b1);
        check("late_ack_fault", fetch_fault, 0);
        retire(0, 0, 0, 0, 0, 0, 32'd0);

        // No ack for TIMEOUT cycles faults.
        for (int i = 0; i < TIMEOUT - 1; i++) step();
        check("pre_fault_req", imem_req, 1);
        check("pre_fault", fetch_fault, 0);
        step();
        check("fault", fetch_fault, 1);
        check("fault_req", imem_req, 0);
        imem_ack = 1'b1; imem_rdata = 32'h1234_5678;
        step();
        step();
        imem_ack = 1'b0;
        check("fault_sticky", fetch_fault, 1);
        check("fault_valid", instr_valid, 0);
        check("fault_instr", instr, 32'hDEAD_BEEF);

`ifdef IFETCH_JR_EN
        do_reset();
        fetch_instr(0, 32'h0000_0008, 1'b0);
        retire(0, 1, 0, 0, 0, 1, 32'h0000_1237);
        check("jr_addr", imem_addr, 32'h0000_1234);
`endif

        // Randomized instruction stream.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TIMEOUT - 1)) : int'($urandom_range(0, 2));
            word = $urandom;
            fetch_instr(w, word, 1'($urandom_range(0, 1)));
            j = ($urandom_range(0, 3) == 0);
            b = 1'($urandom_range(0, 1));
            bne = 1'($urandom_range(0, 1));
            z = 1'($urandom_range(0, 1));
            retire(int'($urandom_range(0, 3)), j, b, bne, z, ($urandom_range(0, 5) == 0), $urandom);
        end
        check("rand_fault", fetch_fault, 0);

        // Reset while in HOLD at pc 0x100, then reset with an in-flight ack.
        do_reset();
        fetch_instr(0, 32'h0800_0040, 1'b0);
        retire(0, 1, 0, 0, 0, 0, 32'd0);
        check("pc_100", pc, 32'h100);
        fetch_instr(0, 32'hCAFE_F00D, 1'b0);
        reset = 1'b1;
        step();
        check("hrst_pc", pc, RESET_PC);
        check("hrst_valid", instr_valid, 0);
        check("hrst_instr", instr, 32'd0);
        check("hrst_req", imem_req, 0);
        reset = 1'b0;
        step();
        check("hrst_fetch_req", imem_req, 1);
        check("hrst_fetch_addr", imem_addr, RESET_PC);
        imem_ack = 1'b1; imem_rdata = 32'h5555_AAAA; reset = 1'b1;
        step();
        imem_ack = 1'b0; reset = 1'b0;
        check("frst_instr", instr, 32'd0);
        check("frst_valid", instr_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
